// File: rtl/ro_compare_counter.sv
// Ring-oscillator PUF comparator: counts synchronised rising edges of two
// oscillators over a fixed window and reports which channel ran faster.
module ro_compare_counter #(
    parameter int WIDTH       = 8,
    parameter int WINDOW      = 800,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [WIDTH-1:0] count_a,
    output logic [WIDTH-1:0] count_b,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic             overflow
);

    // state  | meaning
    // IDLE   | waiting for start, results held
    // SETTLE | flushing synchronisers, edges ignored
    // COUNT  | window running, edges counted
    // DONE   | results valid, done pulse
    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    logic                   prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic [SET_W-1:0]       set_cnt_q, set_cnt_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [WIDTH-1:0]       count_a_q, count_a_d, count_b_q, count_b_d;
    logic                   done_q, done_d;
    logic                   response_q, response_d;
    logic                   tie_q, tie_d;
    logic                   overflow_q, overflow_d;
    logic                   edge_a, edge_b;

    assign edge_a = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
    assign edge_b = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;

    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], ro_a};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], ro_b};
        prev_a_d = sync_a_q[SYNC_STAGES-1];
        prev_b_d = sync_b_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        win_cnt_d  = win_cnt_q;
        count_a_d  = count_a_q;
        count_b_d  = count_b_q;
        done_d     = 1'b0;
        response_d = response_q;
        tie_d      = tie_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    set_cnt_d  = SET_W'(SYNC_STAGES);
                    count_a_d  = '0;
                    count_b_d  = '0;
                    response_d = 1'b0;
                    tie_d      = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            SETTLE: begin
                if (set_cnt_q == '0) begin
                    state_d   = COUNT;
                    win_cnt_d = WIN_W'(WINDOW - 1);
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            COUNT: begin
                if (edge_a) begin
                    if (count_a_q == '1) overflow_d = 1'b1;
                    else                 count_a_d  = count_a_q + WIDTH'(1);
                end
                if (edge_b) begin
                    if (count_b_q == '1) overflow_d = 1'b1;
                    else                 count_b_d  = count_b_q + WIDTH'(1);
                end
                // Compare on the post-increment values so the final window cycle is included.
                if (win_cnt_q == '0) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    response_d = (count_a_d > count_b_d);
                    tie_d      = (count_a_d == count_b_d);
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            prev_a_q   <= 1'b0;
            prev_b_q   <= 1'b0;
            set_cnt_q  <= '0;
            win_cnt_q  <= '0;
            count_a_q  <= '0;
            count_b_q  <= '0;
            done_q     <= 1'b0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
            set_cnt_q  <= set_cnt_d;
            win_cnt_q  <= win_cnt_d;
            count_a_q  <= count_a_d;
            count_b_q  <= count_b_d;
            done_q     <= done_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_a  = count_a_q;
    assign count_b  = count_b_q;
    assign busy     = (state_q == SETTLE) || (state_q == COUNT);
    assign done     = done_q;
    assign response = response_q;
    assign tie      = tie_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_compare_counter.sv
// Scoreboard bench for ro_compare_counter: expected results are queued at start
// and compared when done pulses.
module tb_ro_compare_counter;

    localparam int S = 2;
    localparam int W = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       ro_a = 1'b0, ro_b = 1'b0, ro_a1 = 1'b0, ro_b1 = 1'b0;
    logic [7:0] count_a0, count_b0;
    logic [3:0] count_a1, count_b1;
    logic       busy0, done0, response0, tie0, overflow0;
    logic       busy1, done1, response1, tie1, overflow1;

    ro_compare_counter #(.WIDTH(8), .WINDOW(W), .SYNC_STAGES(S)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .ro_a(ro_a), .ro_b(ro_b),
        .count_a(count_a0), .count_b(count_b0), .busy(busy0), .done(done0),
        .response(response0), .tie(tie0), .overflow(overflow0)
    );

    ro_compare_counter #(.WIDTH(4), .WINDOW(W), .SYNC_STAGES(S)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ro_a(ro_a1), .ro_b(ro_b1),
        .count_a(count_a1), .count_b(count_b1), .busy(busy1), .done(done1),
        .response(response1), .tie(tie1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int pa = 4, pb = 5, ph_a = 0, ph_b = 0;

    typedef struct {
        int ca; int cb; int resp; int tie; int ovf; int at;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input int p_a, input int p_b, input int width, input int at);
        exp_t e;
        int   mx, na, nb;
        mx    = (1 << width) - 1;
        na    = (p_a == 0) ? 0 : W / p_a;
        nb    = (p_b == 0) ? 0 : W / p_b;
        e.ca  = (na > mx) ? mx : na;
        e.cb  = (nb > mx) ? mx : nb;
        e.resp = (e.ca > e.cb) ? 1 : 0;
        e.tie  = (e.ca == e.cb) ? 1 : 0;
        e.ovf  = (na > mx || nb > mx) ? 1 : 0;
        e.at   = at;
        return e;
    endfunction

    // Oscillator stand-ins, updated away from the sampling edge.
    initial forever begin
        @(negedge clk);
        ph_a  = (ph_a + 1) % pa;
        ph_b  = (ph_b + 1) % pb;
        ro_a  = (ph_a < pa / 2);
        ro_b  = (ph_b < pb / 2);
        ro_a1 = ~ro_a1;
    end

    always @(negedge clk) begin
        if (reset && done0) begin
            if (q0.size() == 0) begin
                check("spurious_done0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                check("latency0",  cyc,       e0.at);
                check("count_a0",  count_a0,  e0.ca);
                check("count_b0",  count_b0,  e0.cb);
                check("response0", response0, e0.resp);
                check("tie0",      tie0,      e0.tie);
                check("overflow0", overflow0, e0.ovf);
            end
        end
        if (reset && done1) begin
            if (q1.size() == 0) begin
                check("spurious_done1", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("latency1",  cyc,       e1.at);
                check("count_a1",  count_a1,  e1.ca);
                check("count_b1",  count_b1,  e1.cb);
                check("response1", response1, e1.resp);
                check("tie1",      tie1,      e1.tie);
                check("overflow1", overflow1, e1.ovf);
            end
        end
    end

    task automatic run0(input int p_a, input int p_b);
        pa = p_a;
        pb = p_b;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        q0.push_back(model(pa, pb, 8, cyc + S + W + 2));
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_q0(input int budget);
        int k = 0;
        while (q0.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0) begin
            check("timeout0", q0.size(), 0);
            q0.delete();
        end
    endtask

    task automatic wait_q1(input int budget);
        int k = 0;
        while (q1.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q1.size() != 0) begin
            check("timeout1", q1.size(), 0);
            q1.delete();
        end
    endtask

    initial begin
        int t0;
        int k;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count_a", count_a0,  0);
        check("rst_count_b", count_b0,  0);
        check("rst_busy",    busy0,     0);
        check("rst_done",    done0,     0);
        check("rst_resp",    response0, 0);
        check("rst_tie",     tie0,      0);
        check("rst_ovf",     overflow0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // A faster than B
        run0(4, 5);
        repeat (10) @(negedge clk);
        check("busy_in_run", busy0, 1);
        wait_q0(200);
        repeat (5) @(negedge clk);
        check("hold_count_a", count_a0,  25);
        check("hold_resp",    response0, 1);
        check("idle_busy",    busy0,     0);

        // B faster, then equal
        run0(5, 4);
        wait_q0(200);
        run0(4, 4);
        wait_q0(200);

        // Saturation on the narrow instance
        @(negedge clk);
        start1 = 1'b1;
        q1.push_back(model(2, 0, 4, cyc + S + W + 2));
        @(negedge clk);
        start1 = 1'b0;
        wait_q1(200);

        // Abort at window cycle 40
        run0(4, 5);
        repeat (42) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_count_a", count_a0,  0);
        check("abort_count_b", count_b0,  0);
        check("abort_busy",    busy0,     0);
        check("abort_done",    done0,     0);
        check("abort_resp",    response0, 0);
        check("abort_ovf",     overflow0, 0);
        q0.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_idle_busy", busy0, 0);
        run0(4, 5);
        wait_q0(200);

        // Start re-pulsed mid-window is ignored
        run0(4, 5);
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_q0(200);
        repeat (20) @(negedge clk);

        // start held high retriggers right after DONE
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        t0 = cyc;
        q0.push_back(model(4, 5, 8, t0 + S + W + 2));
        q0.push_back(model(4, 5, 8, t0 + 2 * (S + W) + 5));
        k = 0;
        while (q0.size() > 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        wait_q0(300);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ro_compare_counter.md
RO_COMPARE_COUNTER -- requirements
Module: ro_compare_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each edge counter.
REQ-002 Parameter WINDOW, default 800: measurement window length in clk cycles; legal range is WINDOW >= 1.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on each oscillator input; legal range is SYNC_STAGES >= 2.
REQ-004 clk  in  1: single clock, rising-edge active.
REQ-005 reset  in  1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  in  1: level-sampled request; begins a measurement when sampled high in IDLE.
REQ-007 ro_a  in  1: channel A oscillator (post-mux), asynchronous to clk.
REQ-008 ro_b  in  1: channel B oscillator (post-mux), asynchronous to clk.
REQ-009 count_a  out  WIDTH: channel A rising-edge count for the current or last run.
REQ-010 count_b  out  WIDTH: channel B rising-edge count for the current or last run.
REQ-011 busy  out  1: high in SETTLE and COUNT.
REQ-012 done  out  1: one-cycle pulse marking result valid.
REQ-013 response  out  1: PUF bit, 1 when count_a > count_b.
REQ-014 tie  out  1: 1 when count_a == count_b.
REQ-015 overflow  out  1: 1 when either counter saturated during the run.

Function
REQ-016 Each of ro_a and ro_b SHALL pass through a SYNC_STAGES flop synchroniser followed by one edge-detect flop; a rising edge is a synchronised 0->1 transition.
REQ-017 FSM states SHALL be IDLE, SETTLE, COUNT and DONE; reset state is IDLE.
REQ-018 IDLE -> SETTLE when start=1; on entry count_a, count_b, overflow, response, tie and done SHALL be cleared.
REQ-019 SETTLE SHALL last exactly SYNC_STAGES+1 cycles to flush the synchronisers, then go to COUNT; edges detected in SETTLE SHALL NOT be counted.
REQ-020 COUNT SHALL last exactly WINDOW cycles, tracked by a window counter of width $clog2(WINDOW+1); each detected edge in a COUNT cycle SHALL increment the corresponding counter by 1.
REQ-021 Counters SHALL saturate at 2^WIDTH-1 without wrapping; an increment attempted at saturation SHALL set overflow, which stays set until the next run.
REQ-022 COUNT -> DONE after the last window cycle; in DONE, response, tie and done=1 SHALL be registered from the final counts, and the FSM SHALL return to IDLE on the next cycle.
REQ-023 Latency SHALL be fixed: done is high exactly SYNC_STAGES+1+WINDOW+1 cycles after the cycle in which start is sampled.
REQ-024 count_a, count_b, response, tie and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-025 start SHALL be ignored while busy=1 or done=1; start held high continuously SHALL retrigger a run from IDLE on the cycle after DONE.
REQ-026 Simultaneous edges on both channels in one cycle SHALL each be counted.
REQ-027 When tie=1, response SHALL be 0.

Reset
REQ-028 While reset=0, all flops SHALL clear asynchronously: FSM=IDLE, all outputs 0, synchronisers 0, window counter 0.
REQ-029 reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-030 WIDTH=8, WINDOW=100: ro_a period 4 clk, ro_b period 5 clk, start pulse -> done at start+1+SYNC_STAGES+1+100, count_a=25, count_b=20, response=1, tie=0, overflow=0.
REQ-031 Same as REQ-030 with periods swapped -> count_a=20, count_b=25, response=0, tie=0.
REQ-032 Both channels period 4 -> count_a=count_b=25, tie=1, response=0.
REQ-033 WIDTH=4, WINDOW=100, ro_a period 2, ro_b held 0 -> count_a=15, count_b=0, overflow=1, response=1.
REQ-034 reset=0 for 1 cycle at cycle 40 of COUNT -> all outputs 0 immediately, no done pulse; a new start then yields the REQ-030 results.
REQ-035 start re-pulsed during COUNT -> ignored; exactly one done pulse and REQ-030 results.
